// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 test-pattern source: pattern modes,
// the bar colour table and the configuration register map.
package hub75_pkg;

  typedef enum logic [2:0] {
    BARS     = 3'd0,
    GRADIENT = 3'd1,
    CHECKER  = 3'd2,
    SOLID    = 3'd3,
    SCROLL   = 3'd4
  } tp_mode_e;

  // Configuration register addresses.
  localparam logic [1:0] TP_REG_MODE  = 2'd0;
  localparam logic [1:0] TP_REG_SOLID = 2'd1;

  // Bar colours as {R,G,B} masks, entry 0 is the leftmost bar:
  // White, Yellow, Cyan, Green, Magenta, Red, Blue, Black.
  localparam logic [7:0][2:0] TP_BAR_RGB = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  // Map a raw mode register value to a pattern; unused codes fall back to bars.
  function automatic tp_mode_e tp_decode_mode(input logic [2:0] raw);
    case (raw)
      3'd1:    return GRADIENT;
      3'd2:    return CHECKER;
      3'd3:    return SOLID;
      3'd4:    return SCROLL;
      default: return BARS;
    endcase
  endfunction

endpackage

// File: rtl/hub75_tp_pixel.sv
// Combinational colour function of the test-pattern source: turns a pixel
// position, the active pattern and the solid colour into one RGB pixel.
// SCROLL arrives here with its column already shifted, so it renders as bars.
module hub75_tp_pixel
  import hub75_pkg::*;
#(
  parameter int HPIXEL     = 64,
  parameter int VPIXEL     = 64,
  parameter int BPP        = 8,
  parameter int NUM_BARS   = 8,
  parameter int CHECK_LOG2 = 3
) (
  input  tp_mode_e                   i_mode,
  input  logic [$clog2(HPIXEL)-1:0]  i_col,
  input  logic [$clog2(VPIXEL)-1:0]  i_row,
  input  logic [3*BPP-1:0]           i_solid,
  output logic [2:0][BPP-1:0]        o_pix
);

  localparam int COL_W     = $clog2(HPIXEL);
  localparam int ROW_W     = $clog2(VPIXEL);
  localparam int BAR_SHIFT = COL_W - $clog2(NUM_BARS);

  logic [COL_W+2:0]     bar_ext;
  logic [2:0]           bar_idx;
  logic [2:0]           bar_rgb;
  logic [COL_W+BPP-1:0] grad_ext;
  logic [BPP-1:0]       grad_v;
  logic [COL_W-1:0]     col_sq;
  logic [ROW_W-1:0]     row_sq;
  logic                 chk_black;

  // Evaluate every pattern and select the active one.
  always_comb begin
    bar_ext   = {3'b000, i_col} >> BAR_SHIFT;
    bar_idx   = bar_ext[2:0];
    bar_rgb   = TP_BAR_RGB[bar_idx];
    grad_ext  = {i_col, {BPP{1'b0}}} >> COL_W;
    grad_v    = grad_ext[BPP-1:0];
    col_sq    = i_col >> CHECK_LOG2;
    row_sq    = i_row >> CHECK_LOG2;
    chk_black = col_sq[0] ^ row_sq[0];
    o_pix     = '0;
    case (i_mode)
      GRADIENT: o_pix = {grad_v, grad_v, grad_v};
      CHECKER:  o_pix = chk_black ? '0 : '1;
      SOLID:    o_pix = i_solid;
      default: begin
        for (int c = 0; c < 3; c++) o_pix[c] = {BPP{bar_rgb[c]}};
      end
    endcase
  end

endmodule

// File: rtl/hub75_test_pattern.sv
// HUB75 test-pattern source: answers frame-buffer style pixel reads with a
// generated pattern for every display segment. Config writes are staged and
// promoted on i_frame_start so a pattern change never tears a frame.
// Optional feature macro: HUB75_TP_SCROLL_EN (scroll offset / frame counter).
//
// Read interface: i_rd_en is a request with no backpressure; each request
// in cycle N produces exactly one o_rd_valid pulse in cycle N+2 carrying the
// pixels for that address. o_rd_data holds its last value while o_rd_valid=0.
module hub75_test_pattern
  import hub75_pkg::*;
#(
  parameter int HPIXEL     = 64,
  parameter int VPIXEL     = 64,
  parameter int BPP        = 8,
  parameter int SEGMENTS   = 2,
  parameter int NUM_BARS   = 8,
  parameter int CHECK_LOG2 = 3,
  parameter int SCROLL_DIV = 4,
  localparam int ADDR_W    = $clog2(HPIXEL*VPIXEL)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_cfg_wr_en,
  input  logic [1:0]                        i_cfg_addr,
  input  logic [3*BPP-1:0]                  i_cfg_wr_data,
  input  logic                              i_frame_start,
  input  logic                              i_rd_en,
  input  logic [ADDR_W-1:0]                 i_rd_addr,
  output logic [SEGMENTS-1:0][2:0][BPP-1:0] o_rd_data,
  output logic                              o_rd_valid
);

  localparam int COL_W    = $clog2(HPIXEL);
  localparam int ROW_W    = $clog2(VPIXEL);
  localparam int SEG_ROWS = VPIXEL / SEGMENTS;

  logic [2:0]       stg_mode, act_mode, nxt_stg_mode, eff_mode;
  logic [3*BPP-1:0] stg_solid, act_solid, nxt_stg_solid, eff_solid;
  logic [COL_W-1:0] eff_offset;
  tp_mode_e         eff_mode_e;
  logic [COL_W-1:0] rd_col;
  logic [ROW_W-1:0] rd_row;

  // Staging after this cycle's write; a frame start promotes this value, so
  // a write coincident with the frame start takes effect immediately.
  always_comb begin
    nxt_stg_mode  = stg_mode;
    nxt_stg_solid = stg_solid;
    if (i_cfg_wr_en && i_cfg_addr == TP_REG_MODE)  nxt_stg_mode  = i_cfg_wr_data[2:0];
    if (i_cfg_wr_en && i_cfg_addr == TP_REG_SOLID) nxt_stg_solid = i_cfg_wr_data;
    eff_mode   = i_frame_start ? nxt_stg_mode  : act_mode;
    eff_solid  = i_frame_start ? nxt_stg_solid : act_solid;
    eff_mode_e = tp_decode_mode(eff_mode);
    rd_col     = i_rd_addr[COL_W-1:0];
    rd_row     = i_rd_addr[ADDR_W-1:COL_W];
  end

  // Staging and active configuration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_mode  <= 3'(BARS);
      stg_solid <= '0;
      act_mode  <= 3'(BARS);
      act_solid <= '0;
    end else begin
      stg_mode  <= nxt_stg_mode;
      stg_solid <= nxt_stg_solid;
      if (i_frame_start) begin
        act_mode  <= nxt_stg_mode;
        act_solid <= nxt_stg_solid;
      end
    end
  end

`ifdef HUB75_TP_SCROLL_EN
  localparam int CNT_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  logic [CNT_W-1:0] frame_cnt;
  logic [COL_W-1:0] offset, nxt_offset;
  logic             cnt_last;

  // Offset after this frame start; reads in the same cycle already see it.
  always_comb begin
    cnt_last   = (frame_cnt == CNT_W'(SCROLL_DIV - 1));
    nxt_offset = cnt_last ? offset + COL_W'(1) : offset;
    eff_offset = i_frame_start ? nxt_offset : offset;
  end

  // Frame divider and scroll offset; runs in every mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      offset    <= '0;
    end else if (i_frame_start) begin
      frame_cnt <= cnt_last ? '0 : frame_cnt + CNT_W'(1);
      offset    <= nxt_offset;
    end
  end
`else
  assign eff_offset = '0;
`endif

  logic                           s1_valid;
  tp_mode_e                       s1_mode;
  logic [COL_W-1:0]               s1_col;
  logic [SEGMENTS-1:0][ROW_W-1:0] s1_row;
  logic [3*BPP-1:0]               s1_solid;

  // Stage 1: capture pattern coordinates and the configuration for this read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= BARS;
      s1_col   <= '0;
      s1_row   <= '0;
      s1_solid <= '0;
    end else begin
      s1_valid <= i_rd_en;
      if (i_rd_en) begin
        s1_mode  <= eff_mode_e;
        s1_col   <= (eff_mode_e == SCROLL) ? rd_col + eff_offset : rd_col;
        s1_solid <= eff_solid;
        for (int s = 0; s < SEGMENTS; s++) s1_row[s] <= rd_row + ROW_W'(s * SEG_ROWS);
      end
    end
  end

  logic [SEGMENTS-1:0][2:0][BPP-1:0] pix;

  for (genvar s = 0; s < SEGMENTS; s++) begin : g_seg
    hub75_tp_pixel #(
      .HPIXEL     (HPIXEL),
      .VPIXEL     (VPIXEL),
      .BPP        (BPP),
      .NUM_BARS   (NUM_BARS),
      .CHECK_LOG2 (CHECK_LOG2)
    ) u_pixel (
      .i_mode  (s1_mode),
      .i_col   (s1_col),
      .i_row   (s1_row[s]),
      .i_solid (s1_solid),
      .o_pix   (pix[s])
    );
  end

  // Stage 2: register the coloured pixels; data holds when no read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      o_rd_valid <= s1_valid;
      if (s1_valid) o_rd_data <= pix;
    end
  end

endmodule

// File: tb/tb_hub75_test_pattern.sv
// Directed bench for hub75_test_pattern (HPIXEL=64, SEGMENTS=2,
// CHECK_LOG2=5, SCROLL_DIV=1) with a reference model and expected queue.
module tb_hub75_test_pattern;

  logic                    clk;
  logic                    rst;
  logic                    i_cfg_wr_en;
  logic [1:0]              i_cfg_addr;
  logic [23:0]             i_cfg_wr_data;
  logic                    i_frame_start;
  logic                    i_rd_en;
  logic [11:0]             i_rd_addr;
  logic [1:0][2:0][7:0]    o_rd_data;
  logic                    o_rd_valid;

  hub75_test_pattern #(
    .HPIXEL     (64),
    .VPIXEL     (64),
    .BPP        (8),
    .SEGMENTS   (2),
    .NUM_BARS   (8),
    .CHECK_LOG2 (5),
    .SCROLL_DIV (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_cfg_wr_en   (i_cfg_wr_en),
    .i_cfg_addr    (i_cfg_addr),
    .i_cfg_wr_data (i_cfg_wr_data),
    .i_frame_start (i_frame_start),
    .i_rd_en       (i_rd_en),
    .i_rd_addr     (i_rd_addr),
    .o_rd_data     (o_rd_data),
    .o_rd_valid    (o_rd_valid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [47:0] exp_q[$];
  int          due_q[$];
  logic [47:0] last_data = '0;
  int          checks = 0;
  int          errors = 0;

  // reference model of the configuration
  logic [2:0]  m_stg_mode  = 3'd0;
  logic [2:0]  m_act_mode  = 3'd0;
  logic [23:0] m_stg_solid = 24'h0;
  logic [23:0] m_act_solid = 24'h0;
  int          m_off       = 0;

  task automatic check48(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] model_seg(input int mode, input logic [23:0] solid,
                                            input int off, input int col, input int row);
    int m, c, bar, v;
    m = (mode > 4) ? 0 : mode;
    c = col;
    if (m == 4) c = (col + off) % 64;
    case (m)
      1: begin
        v = (c * 256) / 64;
        v = v % 256;
        return {v[7:0], v[7:0], v[7:0]};
      end
      2: return ((((c / 32) ^ (row / 32)) % 2) == 1) ? 24'h000000 : 24'hFFFFFF;
      3: return solid;
      default: begin
        bar = (c * 8) / 64;
        case (bar % 8)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
    endcase
  endfunction

  function automatic logic [47:0] model_pix(input int addr);
    int col, row;
    col = addr % 64;
    row = addr / 64;
    return {model_seg(int'(m_act_mode), m_act_solid, m_off, col, row + 32),
            model_seg(int'(m_act_mode), m_act_solid, m_off, col, row)};
  endfunction

  // ---------------- monitor ----------------
  // Outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        check1("rd_valid_latency", o_rd_valid, 1'b1);
        if (o_rd_valid) check48("rd_data", o_rd_data, exp_q[0]);
        last_data = exp_q[0];
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end else begin
        check1("no_spurious_valid", o_rd_valid, 1'b0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic wr, input logic [1:0] wa, input logic [23:0] wd,
                      input logic fs, input logic rd, input int ra);
    @(negedge clk);
    i_cfg_wr_en   = wr;
    i_cfg_addr    = wa;
    i_cfg_wr_data = wd;
    i_frame_start = fs;
    i_rd_en       = rd;
    i_rd_addr     = 12'(ra);
    if (wr && wa == 2'd0) m_stg_mode  = wd[2:0];
    if (wr && wa == 2'd1) m_stg_solid = wd;
    if (fs) begin
      m_act_mode  = m_stg_mode;
      m_act_solid = m_stg_solid;
`ifdef HUB75_TP_SCROLL_EN
      m_off = (m_off + 1) % 64;
`endif
    end
    if (rd) begin
      exp_q.push_back(model_pix(ra));
      due_q.push_back(cyc + 2);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 24'h0, 1'b0, 1'b0, 0);
  endtask

  task automatic rd(input int a);
    step(1'b0, 2'd0, 24'h0, 1'b0, 1'b1, a);
  endtask

  task automatic wr(input logic [1:0] a, input logic [23:0] d);
    step(1'b1, a, d, 1'b0, 1'b0, 0);
  endtask

  task automatic fs();
    step(1'b0, 2'd0, 24'h0, 1'b1, 1'b0, 0);
  endtask

  task automatic drain(input string tag);
    idle(4);
    check1(tag, exp_q.size() == 0, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst           = 1'b1;
    i_cfg_wr_en   = 1'b0;
    i_cfg_addr    = 2'd0;
    i_cfg_wr_data = 24'h0;
    i_frame_start = 1'b0;
    i_rd_en       = 1'b0;
    i_rd_addr     = 12'h0;
    repeat (3) @(negedge clk);
    check1("reset_valid", o_rd_valid, 1'b0);
    check48("reset_data", o_rd_data, 48'h0);
    rst = 1'b0;

    // bars after reset, back-to-back reads
    rd(0); rd(8); rd(63); rd(5 * 64 + 40);
    drain("drain_bars");
    check48("hold_data", o_rd_data, last_data);

    // gradient
    wr(2'd0, 24'd1); fs();
    rd(16); rd(63); rd(31 * 64 + 16);
    drain("drain_gradient");

    // checker with 32-pixel squares
    wr(2'd0, 24'd2); fs();
    rd(0); rd(40); rd(31 * 64 + 31);
    drain("drain_checker");

    // shadowing: staged solid colour invisible until the frame start
    wr(2'd0, 24'd0); fs();
    wr(2'd1, 24'h123456); wr(2'd0, 24'd3);
    rd(8); rd(0);
    fs();
    rd(8); rd(100);
    // write coincident with frame start, read in the same cycle
    step(1'b1, 2'd0, 24'd1, 1'b1, 1'b1, 16);
    rd(63);
    drain("drain_shadow");

    // scroll: 6 frame starts so far, two more make the offset 8
    wr(2'd0, 24'd4); fs();
    fs(); fs();
    rd(0); rd(56); rd(8);
    repeat (56) fs();
    rd(0); rd(8);
    // unused mode code falls back to bars
    wr(2'd0, 24'd6); fs();
    rd(8);
    drain("drain_scroll");

    // reset during a stream of reads
    wr(2'd0, 24'd3); fs();
    rd(0); rd(1); rd(2);
    @(posedge clk);
    #2;
    i_rd_en = 1'b0;
    rst     = 1'b1;
    #1;
    check1("midreset_valid", o_rd_valid, 1'b0);
    check48("midreset_data", o_rd_data, 48'h0);
    exp_q.delete();
    due_q.delete();
    m_stg_mode  = 3'd0;
    m_act_mode  = 3'd0;
    m_stg_solid = 24'h0;
    m_act_solid = 24'h0;
    m_off       = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd(8); rd(0);
    drain("drain_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
